// File: rtl/cmt_player.sv
// cmt_player: cassette (CMT) playback source.
// Bytes from an image loader are queued in a small FIFO and serialised as
// 600-baud frames (1 start bit 0, 8 data bits LSB first, 2 stop bits 1).
// Each bit lasts 8 sub-ticks of DIV8 clk cycles.
// Optional build macro CMT_PLAYER_FSK_EN: tape_out becomes an FSK tone
// (1 -> 2400 Hz, 0 -> 1200 Hz, phase-continuous) instead of the plain NRZ
// bit level.
module cmt_player #(
    parameter int DIV8       = 2982,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  flush,
    input  logic                  motor,
    output logic                  tape_out,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (DIV8 > 1) ? $clog2(DIV8) : 1;

    localparam logic [CW-1:0]         DIV_LAST = CW'(DIV8 - 1);
    localparam logic [CW-1:0]         DIV_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);

`ifdef CMT_PLAYER_FSK_EN
    localparam logic TAPE_IDLE = 1'b0;
`else
    localparam logic TAPE_IDLE = 1'b1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]            mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   level_reg;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Bit timing
    logic [CW-1:0]         div_cnt_reg;
    logic [2:0]            sub_reg;
    logic                  tick;
    logic                  boundary;

    // Transmitter
    state_t                state_reg;
    state_t                state_next;
    logic [2:0]            bit_cnt_reg;
    logic [2:0]            bit_cnt_next;
    logic [7:0]            data_reg;
    logic                  busy_reg;
    logic                  tape_reg;
    logic                  tape_next;

    // Level is at most DEPTH, so its MSB alone marks a full FIFO.
    assign full      = level_reg[DEPTH_LOG2];
    assign empty     = (level_reg == '0);
    assign push      = din_valid & ~full;
    assign din_ready = ~full;
    assign level     = level_reg;
    assign busy      = busy_reg;
    assign tape_out  = tape_reg;

    assign tick     = (div_cnt_reg == DIV_LAST);
    assign boundary = tick && (sub_reg == 3'd7);

    // Line value carried by a given transmitter position.
    function automatic logic bit_value(input state_t st, input logic [2:0] idx,
                                       input logic [7:0] data);
        logic v;
        case (st)
            ST_START: v = 1'b0;
            ST_DATA:  v = data[idx];
            default:  v = 1'b1;
        endcase
        return v;
    endfunction

    // Free-running sub-tick divider and tick-within-bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_reg <= '0;
            sub_reg     <= 3'd0;
        end else if (flush) begin
            div_cnt_reg <= '0;
            sub_reg     <= 3'd0;
        end else begin
            div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_ONE;
            if (tick) begin
                sub_reg <= sub_reg + 3'd1;
            end
        end
    end

    // FIFO write port; the storage array is not reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Registered read: the popped byte lands in the transmit holding register.
    always_ff @(posedge clk) begin
        if (pop && !flush) begin
            data_reg <= mem[rd_ptr_reg];
        end
    end

    // FIFO pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_ONE;
                2'b01:   level_reg <= level_reg - LVL_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Frame sequencing: all moves happen on bit boundaries; the end of the
    // second stop bit chains straight into a new start bit when data waits.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        pop          = 1'b0;
        if (boundary) begin
            case (state_reg)
                ST_IDLE: begin
                    if (motor && !empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end
                end
                ST_START: begin
                    state_next   = ST_DATA;
                    bit_cnt_next = 3'd0;
                end
                ST_DATA: begin
                    if (bit_cnt_reg == 3'd7) begin
                        state_next   = ST_STOP;
                        bit_cnt_next = 3'd0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
                default: begin
                    if (bit_cnt_reg == 3'd1) begin
                        bit_cnt_next = 3'd0;
                        if (motor && !empty) begin
                            pop        = 1'b1;
                            state_next = ST_START;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            endcase
        end
    end

    // Next tape line value.
    always_comb begin
`ifdef CMT_PLAYER_FSK_EN
        // Mark toggles every tick, space every second tick; the shared
        // tick parity keeps the phase continuous across bit changes.
        tape_next = tape_reg;
        if (state_next == ST_IDLE && !motor) begin
            tape_next = 1'b0;
        end else if (tick && (bit_value(state_reg, bit_cnt_reg, data_reg) || sub_reg[0])) begin
            tape_next = ~tape_reg;
        end
`else
        tape_next = bit_value(state_next, bit_cnt_next, data_reg);
`endif
    end

    // Transmitter state with registered busy and tape outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 3'd0;
            busy_reg    <= 1'b0;
            tape_reg    <= TAPE_IDLE;
        end else if (flush) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 3'd0;
            busy_reg    <= 1'b0;
            tape_reg    <= TAPE_IDLE;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            busy_reg    <= (state_next != ST_IDLE);
            tape_reg    <= tape_next;
        end
    end

endmodule

// File: tb/tb_cmt_player.sv
// tb_cmt_player: self-checking bench for cmt_player with DIV8=2 (one bit is
// 16 clk, one frame 176 clk). Expected serial streams come from a byte queue
// and the frame format (start 0, data LSB first, two stop 1s).
module tb_cmt_player;

    localparam int DIV8      = 2;
    localparam int DL        = 4;
    localparam int DEPTH     = 1 << DL;
    localparam int BIT_CLK   = 8 * DIV8;
    localparam int FRAME_CLK = 11 * BIT_CLK;
    localparam int MAXS      = 4096;

`ifdef CMT_PLAYER_FSK_EN
    localparam logic IDLE_TAPE = 1'b0;
`else
    localparam logic IDLE_TAPE = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          flush = 1'b0;
    logic          motor = 1'b0;
    logic          tape_out;
    logic [DL:0]   level;
    logic          busy;

    int checks = 0;
    int failures = 0;

    logic          samp_tape [MAXS];
    logic          samp_busy [MAXS];
    logic [7:0]    exp_q [$];

    cmt_player #(.DIV8(DIV8), .DEPTH_LOG2(DL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .flush     (flush),
        .motor     (motor),
        .tape_out  (tape_out),
        .level     (level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model / helpers (no comparisons) ----------------

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Recover the bit value of bit slot k from the recorded samples.
    function automatic logic decode_bit(input int k);
`ifdef CMT_PLAYER_FSK_EN
        int t;
        t = 0;
        for (int e = BIT_CLK*k + 1; e <= BIT_CLK*k + BIT_CLK; e++)
            if (samp_tape[e] !== samp_tape[e-1]) t++;
        if (t == 8) return 1'b1;
        if (t == 4) return 1'b0;
        return 1'bx;
`else
        return samp_tape[BIT_CLK*k + BIT_CLK/2];
`endif
    endfunction

    function automatic int busy_high(input int n);
        int c;
        c = 0;
        for (int j = 0; j < n; j++)
            if (samp_busy[j] === 1'b1) c++;
        return c;
    endfunction

    // Records n samples; the first one is taken at the current negedge.
    task automatic record(input int n);
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clk);
            samp_tape[j] = tape_out;
            samp_busy[j] = busy;
        end
    endtask

    task automatic push_one(input logic [7:0] b);
        @(negedge clk);
        din = b;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_busy_rise(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Decodes recorded frames, prints one line per frame, counts bad frames.
    task automatic compare_stream(input int nframes, output int errs);
        logic [7:0] obs;
        logic st, sp1, sp2;
        errs = 0;
        for (int f = 0; f < nframes; f++) begin
            st = decode_bit(f*11);
            for (int i = 0; i < 8; i++) obs[i] = decode_bit(f*11 + 1 + i);
            sp1 = decode_bit(f*11 + 9);
            sp2 = decode_bit(f*11 + 10);
            if (st !== frame_bit(exp_q[f], 0) || obs !== exp_q[f] ||
                sp1 !== frame_bit(exp_q[f], 9) || sp2 !== frame_bit(exp_q[f], 10))
                errs++;
            $display("  frame %0d: sent=%02h start=%b data=%02h stop=%b%b",
                     f, exp_q[f], st, obs, sp1, sp2);
        end
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        reset_n = 1'b0;
        motor = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (level !== '0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready: got %b expected 1", din_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (tape_out !== IDLE_TAPE) begin failures++; $display("FAIL reset_tape: got %b expected %b", tape_out, IDLE_TAPE); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
        checks++; if (tape_out !== IDLE_TAPE) begin failures++; $display("FAIL idle_tape: got %b expected %b", tape_out, IDLE_TAPE); end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        bit ok;
        int errs, bh;
        exp_q = {};
        exp_q.push_back(8'hA5);
        motor = 1'b1;
        push_one(8'hA5);
        wait_busy_rise(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++; $display("FAIL single_start: got busy=%b expected 1 within 40 clk", busy);
        end else begin
            record(FRAME_CLK + 1);
            compare_stream(1, errs);
            checks++; if (errs !== 0) begin failures++; $display("FAIL single_bits: got %0d bad frames expected 0", errs); end
            bh = busy_high(FRAME_CLK);
            checks++; if (bh !== FRAME_CLK || samp_busy[FRAME_CLK] !== 1'b0) begin
                failures++; $display("FAIL single_busy_len: got %0d (end %b) expected %0d (end 0)", bh, samp_busy[FRAME_CLK], FRAME_CLK);
            end
            checks++; if (level !== '0) begin failures++; $display("FAIL single_level: got %0d expected 0", level); end
        end
        motor = 1'b0;
        $display("test_single_frame done");
    endtask

    task automatic test_back_to_back();
        bit ok;
        int errs, bh;
        logic [7:0] b;
        motor = 1'b0;
        exp_q = {};
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            push_one(b);
            checks++; if (level !== (DL+1)'(i + 1)) begin failures++; $display("FAIL b2b_level_push%0d: got %0d expected %0d", i, level, i + 1); end
        end
        motor = 1'b1;
        wait_busy_rise(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++; $display("FAIL b2b_start: got busy=%b expected 1 within 40 clk", busy);
        end else begin
            record(5*FRAME_CLK + 1);
            compare_stream(5, errs);
            checks++; if (errs !== 0) begin failures++; $display("FAIL b2b_bits: got %0d bad frames expected 0", errs); end
            bh = busy_high(5*FRAME_CLK);
            checks++; if (bh !== 5*FRAME_CLK || samp_busy[5*FRAME_CLK] !== 1'b0) begin
                failures++; $display("FAIL b2b_busy_len: got %0d expected %0d", bh, 5*FRAME_CLK);
            end
            checks++; if (level !== '0) begin failures++; $display("FAIL b2b_level_end: got %0d expected 0", level); end
        end
        motor = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_overflow();
        bit ok;
        int errs, bh;
        logic [7:0] b;
        motor = 1'b0;
        exp_q = {};
        for (int i = 0; i < DEPTH + 1; i++) begin
            @(negedge clk);
            b = 8'($urandom_range(0, 255));
            din = b;
            din_valid = 1'b1;
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
        end
        @(negedge clk);
        din_valid = 1'b0;
        checks++; if (level !== (DL+1)'(DEPTH)) begin failures++; $display("FAIL ovf_level: got %0d expected %0d", level, DEPTH); end
        checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL ovf_din_ready: got %b expected 0", din_ready); end
        repeat (50) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovf_no_frame: got busy=%b expected 0", busy); end
        checks++; if (level !== (DL+1)'(DEPTH)) begin failures++; $display("FAIL ovf_level_hold: got %0d expected %0d", level, DEPTH); end
        motor = 1'b1;
        wait_busy_rise(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++; $display("FAIL ovf_start: got busy=%b expected 1 within 40 clk", busy);
        end else begin
            record(DEPTH*FRAME_CLK + 1);
            compare_stream(DEPTH, errs);
            checks++; if (errs !== 0) begin failures++; $display("FAIL ovf_bits: got %0d bad frames expected 0", errs); end
            bh = busy_high(DEPTH*FRAME_CLK);
            checks++; if (bh !== DEPTH*FRAME_CLK || samp_busy[DEPTH*FRAME_CLK] !== 1'b0) begin
                failures++; $display("FAIL ovf_busy_len: got %0d expected %0d", bh, DEPTH*FRAME_CLK);
            end
            checks++; if (din_ready !== 1'b1 || level !== '0) begin
                failures++; $display("FAIL ovf_drained: got level=%0d ready=%b expected 0/1", level, din_ready);
            end
        end
        motor = 1'b0;
        $display("test_overflow done");
    endtask

    task automatic test_push_pop();
        bit ok;
        int fall_at;
        motor = 1'b0;
        push_one(8'($urandom_range(0, 255)));
        push_one(8'($urandom_range(0, 255)));
        motor = 1'b1;
        wait_busy_rise(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++; $display("FAIL pp_start: got busy=%b expected 1 within 40 clk", busy);
        end else begin
            checks++; if (level !== (DL+1)'(1)) begin failures++; $display("FAIL pp_level_first_pop: got %0d expected 1", level); end
            // Push lands on the very edge where frame 2 pops its byte.
            repeat (FRAME_CLK - 1) @(negedge clk);
            din = 8'($urandom_range(0, 255));
            din_valid = 1'b1;
            @(negedge clk);
            din_valid = 1'b0;
            checks++; if (level !== (DL+1)'(1)) begin failures++; $display("FAIL pp_level_same_cycle: got %0d expected 1", level); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pp_chained: got busy=%b expected 1", busy); end
            fall_at = -1;
            for (int j = 1; j <= 3*FRAME_CLK; j++) begin
                @(negedge clk);
                if (busy === 1'b0) begin fall_at = j; break; end
            end
            checks++; if (fall_at !== 2*FRAME_CLK) begin failures++; $display("FAIL pp_busy_fall: got %0d clk expected %0d", fall_at, 2*FRAME_CLK); end
            checks++; if (level !== '0) begin failures++; $display("FAIL pp_level_end: got %0d expected 0", level); end
        end
        motor = 1'b0;
        $display("test_push_pop done");
    endtask

    task automatic test_motor_drop();
        bit ok;
        int fall_at, seen;
        motor = 1'b0;
        for (int i = 0; i < 3; i++) push_one(8'($urandom_range(0, 255)));
        motor = 1'b1;
        wait_busy_rise(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++; $display("FAIL md_start: got busy=%b expected 1 within 40 clk", busy);
        end else begin
            checks++; if (level !== (DL+1)'(2)) begin failures++; $display("FAIL md_level_start: got %0d expected 2", level); end
            repeat (4*BIT_CLK) @(negedge clk);
            motor = 1'b0;
            fall_at = -1;
            for (int j = 1; j <= 2*FRAME_CLK; j++) begin
                @(negedge clk);
                if (busy === 1'b0) begin fall_at = j; break; end
            end
            checks++; if (fall_at !== FRAME_CLK - 4*BIT_CLK) begin
                failures++; $display("FAIL md_frame_completes: got fall after %0d clk expected %0d", fall_at, FRAME_CLK - 4*BIT_CLK);
            end
            seen = 0;
            repeat (100) begin
                @(negedge clk);
                if (busy !== 1'b0) seen++;
            end
            checks++; if (seen !== 0) begin failures++; $display("FAIL md_no_new_frame: got %0d busy clk expected 0", seen); end
            checks++; if (level !== (DL+1)'(2)) begin failures++; $display("FAIL md_level_hold: got %0d expected 2", level); end
            checks++; if (tape_out !== IDLE_TAPE) begin failures++; $display("FAIL md_idle_tape: got %b expected %b", tape_out, IDLE_TAPE); end
            motor = 1'b1;
            wait_busy_rise(40, ok);
            checks++; if (ok !== 1'b1) begin failures++; $display("FAIL md_resume: got busy=%b expected 1 within 40 clk", busy); end
            checks++; if (level !== (DL+1)'(1)) begin failures++; $display("FAIL md_level_resume: got %0d expected 1", level); end
        end
        motor = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (level !== '0 || busy !== 1'b0) begin failures++; $display("FAIL md_cleanup: got level=%0d busy=%b expected 0/0", level, busy); end
        $display("test_motor_drop done");
    endtask

    task automatic test_flush();
        bit ok;
        int seen;
        motor = 1'b1;
        push_one(8'($urandom_range(0, 255)));
        wait_busy_rise(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++; $display("FAIL fl_start: got busy=%b expected 1 within 40 clk", busy);
        end else begin
            repeat (50) @(negedge clk);
            din = 8'($urandom_range(0, 255));
            din_valid = 1'b1;
            flush = 1'b1;
            @(negedge clk);
            din_valid = 1'b0;
            flush = 1'b0;
            checks++; if (level !== '0) begin failures++; $display("FAIL fl_level: got %0d expected 0", level); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fl_busy: got %b expected 0", busy); end
            checks++; if (tape_out !== IDLE_TAPE) begin failures++; $display("FAIL fl_tape: got %b expected %b", tape_out, IDLE_TAPE); end
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (busy !== 1'b0) seen++;
            end
            checks++; if (seen !== 0 || level !== '0) begin failures++; $display("FAIL fl_push_dropped: got busy clk=%0d level=%0d expected 0/0", seen, level); end
        end
        motor = 1'b0;
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        bit ok;
        int errs, seen;
        logic [7:0] b;
        motor = 1'b1;
        push_one(8'($urandom_range(0, 255)));
        wait_busy_rise(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++; $display("FAIL rm_start: got busy=%b expected 1 within 40 clk", busy);
        end else begin
            repeat (40) @(negedge clk);
            #2 reset_n = 1'b0;
            #1;
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy_async: got %b expected 0", busy); end
            checks++; if (level !== '0) begin failures++; $display("FAIL rm_level_async: got %0d expected 0", level); end
            checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL rm_ready_async: got %b expected 1", din_ready); end
            checks++; if (tape_out !== IDLE_TAPE) begin failures++; $display("FAIL rm_tape_async: got %b expected %b", tape_out, IDLE_TAPE); end
            @(negedge clk);
            reset_n = 1'b1;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (busy !== 1'b0) seen++;
            end
            checks++; if (seen !== 0) begin failures++; $display("FAIL rm_no_partial: got %0d busy clk expected 0", seen); end
            b = 8'($urandom_range(0, 255));
            exp_q = {};
            exp_q.push_back(b);
            push_one(b);
            wait_busy_rise(40, ok);
            checks++;
            if (ok !== 1'b1) begin
                failures++; $display("FAIL rm_restart: got busy=%b expected 1 within 40 clk", busy);
            end else begin
                record(FRAME_CLK + 1);
                compare_stream(1, errs);
                checks++; if (errs !== 0) begin failures++; $display("FAIL rm_bits: got %0d bad frames expected 0", errs); end
                checks++; if (busy_high(FRAME_CLK) !== FRAME_CLK || samp_busy[FRAME_CLK] !== 1'b0) begin
                    failures++; $display("FAIL rm_busy_len: got %0d expected %0d", busy_high(FRAME_CLK), FRAME_CLK);
                end
            end
        end
        motor = 1'b0;
        $display("test_reset_mid done");
    endtask

`ifdef CMT_PLAYER_FSK_EN
    task automatic test_fsk();
        bit ok;
        int t, nz;
        motor = 1'b1;
        push_one(8'h00);
        wait_busy_rise(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++; $display("FAIL fsk_start: got busy=%b expected 1 within 40 clk", busy);
        end else begin
            record(FRAME_CLK + 1);
            for (int k = 0; k < 11; k++) begin
                t = 0;
                for (int e = BIT_CLK*k + 1; e <= BIT_CLK*k + BIT_CLK; e++)
                    if (samp_tape[e] !== samp_tape[e-1]) t++;
                checks++;
                if (t !== ((k < 9) ? 4 : 8)) begin
                    failures++; $display("FAIL fsk_toggles_bit%0d: got %0d expected %0d", k, t, (k < 9) ? 4 : 8);
                end
            end
        end
        motor = 1'b0;
        repeat (4) @(negedge clk);
        record(20);
        nz = 0;
        for (int j = 0; j < 20; j++) if (samp_tape[j] !== 1'b0) nz++;
        checks++; if (nz !== 0) begin failures++; $display("FAIL fsk_motor_off_hold: got %0d nonzero samples expected 0", nz); end
        $display("test_fsk done");
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_push_pop();
        test_motor_drop();
        test_flush();
        test_reset_mid();
`ifdef CMT_PLAYER_FSK_EN
        test_fsk();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
